armored40_rx_seq: RTL
=====================

// Module: armored40_rx_seq
// PURPOSE
//  Bring-up and recovery sequencer for the armored40 multi-lane receive path.
//  Drives the analog (rst_rxa) and digital (rst_rxd) RX resets, waits for all-lane
//  CDR freqlock and word lock with timeouts, and retries the whole sequence on failure.
//  Once every lane holds word lock it raises link_up and supervises for lock loss.
//  Runs in the clk100 management domain; lock inputs arrive from other clock domains.
// PARAMETERS
//  NUM_LN     4    number of lanes
//  RST_CNTR   16   reset hold = 2**RST_CNTR cycles (6 for fast sim)
//  FREQ_TMO   2**20  cycles allowed in WAIT_FREQ before retry
//  WORD_TMO   2**20  cycles allowed in WAIT_WORD before retry
//  DROP_CYC   1024 consecutive cycles with any wordlock low in RUN before retry
//  MAX_RETRY  7    consecutive failed attempts before link_fail is raised (1..15)
// PORTS
//  clk100       in   1       management clock; the only clock
//  rst100       in   1       synchronous, active-high reset
//  rx_freqlock  in   NUM_LN  per-lane CDR lock, async to clk100
//  rx_wordlock  in   NUM_LN  per-lane word lock, async to clk100
//  rst_rxa      out  1       analog RX reset to the rx pin array
//  rst_rxd      out  1       digital RX reset to the rx pin array
//  link_up      out  1       all lanes locked, state RUN
//  link_fail    out  1       sticky: retry_cnt reached MAX_RETRY; cleared on RUN entry
//  retry_cnt    out  4       consecutive failed attempts, saturating at 15
//  lane_miss    out  NUM_LN  lanes lacking the awaited lock at the last failure
//  seq_state    out  3       current state code (debug)
// BEHAVIOUR
//  - Sync: each rx_freqlock/rx_wordlock bit through 2-flop synchronizer (fs/ws);
//    all decisions use fs/ws (2-cycle input latency). Synchronizers also reset.
//  - States: RST_ANA=0, WAIT_FREQ=1, RST_DIG=2, WAIT_WORD=3, RUN=4, BACKOFF=5.
//    One shared timer tmr, cleared on every state transition. All outputs are
//    registered, updated on the same edge as the state register.
//  - Reset: state RST_ANA, tmr=0, rst_rxa=1, rst_rxd=1, link_up=0, link_fail=0,
//    retry_cnt=0, lane_miss=0, drop counter=0. rst100 mid-sequence restarts here.
//  - RST_ANA: rxa=1 rxd=1; at tmr==2**RST_CNTR-1 -> WAIT_FREQ.
//  - WAIT_FREQ: rxa=0 rxd=1; &fs -> RST_DIG; else tmr==FREQ_TMO-1 -> BACKOFF with
//    lane_miss=~fs. Success wins over timeout in the same cycle.
//  - RST_DIG: rxa=0 rxd=1; any fs low -> BACKOFF (lane_miss=~fs);
//    else tmr==2**RST_CNTR-1 -> WAIT_WORD.
//  - WAIT_WORD: rxa=0 rxd=0; priority: any fs low -> BACKOFF (lane_miss=~fs);
//    &ws -> RUN; tmr==WORD_TMO-1 -> BACKOFF (lane_miss=~ws).
//  - RUN: rxa=0 rxd=0 link_up=1; on entry retry_cnt=0, link_fail=0, lane_miss=0.
//    Any fs low -> BACKOFF immediately (lane_miss=~fs). Drop counter increments
//    while any ws low, clears when &ws; reaching DROP_CYC -> BACKOFF (lane_miss=~ws).
//    fs loss takes precedence over drop expiry.
//  - BACKOFF: rxa=1 rxd=1 link_up=0; on entry retry_cnt+1 (saturate 15);
//    link_fail set when new retry_cnt >= MAX_RETRY; hold 2**RST_CNTR cycles
//    -> RST_ANA. link_fail stays set through further retries.
//  - link_up deasserts on the same edge BACKOFF is entered.
//  - Timer width sized to max(FREQ_TMO, WORD_TMO, 2**RST_CNTR); never wraps.
// TESTING (RST_CNTR=4, FREQ_TMO=64, WORD_TMO=64, DROP_CYC=8, MAX_RETRY=3)
//  1 Reset, all freqlock=F at cycle 40, wordlock=F at 80 -> rxa falls at 16,
//    rxd falls 16 cycles after fs seen, link_up=1 two cycles after ws seen.
//  2 Lane 2 freqlock never rises -> BACKOFF after 64 cycles in WAIT_FREQ,
//    lane_miss=4'b0100, retry_cnt=1; after 3 attempts link_fail=1, retry repeats.
//  3 In RUN, wordlock lane 0 low 7 cycles then high -> no retry; low 8 cycles
//    -> BACKOFF, link_up=0, lane_miss=4'b0001.
//  4 In RUN, freqlock lane 3 drops -> BACKOFF 3 cycles later (2 sync + 1);
//    next successful lock clears retry_cnt and link_fail.
//  5 rst100 pulsed while in WAIT_WORD -> next cycle RST_ANA, rxa=rxd=1, all
//    counters and flags zero.
//  6 fs and timeout coincide at tmr==63 in WAIT_FREQ -> RST_DIG, not BACKOFF.

Source files
------------

// File: rtl/armored40_rx_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | armored40_rx_seq                                                         |
// | Bring-up / recovery sequencer for the armored40 multi-lane RX path.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module armored40_rx_seq #(
   parameter int NUM_LN    = 4,
   parameter int RST_CNTR  = 16,
   parameter int FREQ_TMO  = 2**20,
   parameter int WORD_TMO  = 2**20,
   parameter int DROP_CYC  = 1024,
   parameter int MAX_RETRY = 7
) (
   input  logic              clk100,
   input  logic              rst100,
   input  logic [NUM_LN-1:0] rx_freqlock,
   input  logic [NUM_LN-1:0] rx_wordlock,
   output logic              rst_rxa,
   output logic              rst_rxd,
   output logic              link_up,
   output logic              link_fail,
   output logic [3:0]        retry_cnt,
   output logic [NUM_LN-1:0] lane_miss,
   output logic [2:0]        seq_state
);

   localparam int C_HOLD    = 2**RST_CNTR;
   localparam int C_TMO_A   = (FREQ_TMO > WORD_TMO) ? FREQ_TMO : WORD_TMO;
   localparam int C_TMO_MAX = (C_TMO_A > C_HOLD) ? C_TMO_A : C_HOLD;
   localparam int C_TMR_W   = $clog2(C_TMO_MAX + 1);
   localparam int C_DROP_W  = $clog2(DROP_CYC + 1);

   localparam logic [C_TMR_W-1:0]  C_HOLD_LAST = C_TMR_W'(C_HOLD - 1);
   localparam logic [C_TMR_W-1:0]  C_FREQ_LAST = C_TMR_W'(FREQ_TMO - 1);
   localparam logic [C_TMR_W-1:0]  C_WORD_LAST = C_TMR_W'(WORD_TMO - 1);
   localparam logic [C_DROP_W-1:0] C_DROP_LAST = C_DROP_W'(DROP_CYC - 1);
   localparam logic [3:0]          C_MAX_RETRY = 4'(MAX_RETRY);

   typedef enum logic [2:0] {
      ST_RST_ANA   = 3'd0,
      ST_WAIT_FREQ = 3'd1,
      ST_RST_DIG   = 3'd2,
      ST_WAIT_WORD = 3'd3,
      ST_RUN       = 3'd4,
      ST_BACKOFF   = 3'd5
   } state_t;

   logic [NUM_LN-1:0]   fs_meta_q, fs_q, ws_meta_q, ws_q;
   state_t              state_q, state_d;
   logic [C_TMR_W-1:0]  tmr_q, tmr_d;
   logic [C_DROP_W-1:0] drop_q, drop_d;
   logic [3:0]          retry_q, retry_d;
   logic                fail_q, fail_d;
   logic [NUM_LN-1:0]   miss_q, miss_d;
   logic                rxa_q, rxa_d, rxd_q, rxd_d, up_q, up_d;
   logic                w_fs_all, w_ws_all;

   assign w_fs_all = &fs_q;
   assign w_ws_all = &ws_q;

   always_comb begin
      state_d = state_q;
      tmr_d   = (tmr_q == '1) ? tmr_q : tmr_q + 1'b1;
      drop_d  = drop_q;
      retry_d = retry_q;
      fail_d  = fail_q;
      miss_d  = miss_q;
      case (state_q)
         ST_RST_ANA: begin
            if (tmr_q == C_HOLD_LAST) state_d = ST_WAIT_FREQ;
         end
         ST_WAIT_FREQ: begin
            if (w_fs_all) begin
               state_d = ST_RST_DIG;
            end else if (tmr_q == C_FREQ_LAST) begin
               state_d = ST_BACKOFF;
               miss_d  = ~fs_q;
            end
         end
         ST_RST_DIG: begin
            if (!w_fs_all) begin
               state_d = ST_BACKOFF;
               miss_d  = ~fs_q;
            end else if (tmr_q == C_HOLD_LAST) begin
               state_d = ST_WAIT_WORD;
            end
         end
         ST_WAIT_WORD: begin
            if (!w_fs_all) begin
               state_d = ST_BACKOFF;
               miss_d  = ~fs_q;
            end else if (w_ws_all) begin
               state_d = ST_RUN;
            end else if (tmr_q == C_WORD_LAST) begin
               state_d = ST_BACKOFF;
               miss_d  = ~ws_q;
            end
         end
         ST_RUN: begin
            // Losing frequency lock is fatal at once; word-lock loss gets a grace window.
            if (!w_fs_all) begin
               state_d = ST_BACKOFF;
               miss_d  = ~fs_q;
            end else if (!w_ws_all) begin
               if (drop_q == C_DROP_LAST) begin
                  state_d = ST_BACKOFF;
                  miss_d  = ~ws_q;
               end else begin
                  drop_d = drop_q + 1'b1;
               end
            end else begin
               drop_d = '0;
            end
         end
         ST_BACKOFF: begin
            if (tmr_q == C_HOLD_LAST) state_d = ST_RST_ANA;
         end
         default: state_d = ST_RST_ANA;
      endcase

      if (state_d != state_q) begin
         tmr_d  = '0;
         drop_d = '0;
         if (state_d == ST_RUN) begin
            retry_d = '0;
            fail_d  = 1'b0;
            miss_d  = '0;
         end
         if (state_d == ST_BACKOFF) begin
            retry_d = (retry_q == 4'hf) ? retry_q : retry_q + 1'b1;
            if (retry_d >= C_MAX_RETRY) fail_d = 1'b1;
         end
      end

      rxa_d = (state_d == ST_RST_ANA) || (state_d == ST_BACKOFF);
      rxd_d = !((state_d == ST_WAIT_WORD) || (state_d == ST_RUN));
      up_d  = (state_d == ST_RUN);
   end

   always_ff @(posedge clk100) begin
      if (rst100) begin
         fs_meta_q <= '0;
         fs_q      <= '0;
         ws_meta_q <= '0;
         ws_q      <= '0;
         state_q   <= ST_RST_ANA;
         tmr_q     <= '0;
         drop_q    <= '0;
         retry_q   <= '0;
         fail_q    <= 1'b0;
         miss_q    <= '0;
         rxa_q     <= 1'b1;
         rxd_q     <= 1'b1;
         up_q      <= 1'b0;
      end else begin
         fs_meta_q <= rx_freqlock;
         fs_q      <= fs_meta_q;
         ws_meta_q <= rx_wordlock;
         ws_q      <= ws_meta_q;
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         drop_q    <= drop_d;
         retry_q   <= retry_d;
         fail_q    <= fail_d;
         miss_q    <= miss_d;
         rxa_q     <= rxa_d;
         rxd_q     <= rxd_d;
         up_q      <= up_d;
      end
   end

   assign rst_rxa   = rxa_q;
   assign rst_rxd   = rxd_q;
   assign link_up   = up_q;
   assign link_fail = fail_q;
   assign retry_cnt = retry_q;
   assign lane_miss = miss_q;
   assign seq_state = state_q;

endmodule
`default_nettype wire
